fetch_buffer: RTL and testbench

Instruction queue between the fetch stage and decode. It accepts fetched instruction bundles (valid, pc, instr, guesses_branch, prediction) from fetch, buffers them in order, and presents them one per cycle to decode under a valid/ready handshake. It absorbs decode back-pressure so fetch can keep running. It discards all buffered instructions when branch feedback reports a mispredict.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/fetch_buffer.sv | 117 +++++++++++
 tb/tb_fetch_buffer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared core types; ADDR_WIDTH defaults to 32 when riscv_core.svh has not set it.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package riscv_pkg;

  localparam int unsigned ADDR_W  = `ADDR_WIDTH;
  localparam int unsigned INSTR_W = 32;

  // One fetched instruction as it travels from fetch to decode.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               guesses_branch;
    logic [ADDR_W-1:0]  prediction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order instruction queue between fetch and decode, flushed on mispredict.
// Optional macro FETCH_BUF_BYPASS_EN adds a zero-latency path for an empty buffer.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     in_valid,
  input  logic [`ADDR_WIDTH-1:0]   in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     in_guesses_branch,
  input  logic [`ADDR_WIDTH-1:0]   in_prediction,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [`ADDR_WIDTH-1:0]   out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_guesses_branch,
  output logic [`ADDR_WIDTH-1:0]   out_prediction,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t             mem_q [DEPTH];
  fetch_entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;

  fetch_entry_t             in_entry_c;
  fetch_entry_t             head_c;
  logic                     empty_c;
  logic                     full_c;
  logic                     bypass_c;
  logic                     push_c;
  logic                     pop_c;

  // Handshake decode and head selection.
  always_comb begin
    in_entry_c = '{pc:             in_pc,
                   instr:          in_instr,
                   guesses_branch: in_guesses_branch,
                   prediction:     in_prediction};
    empty_c    = (count_q == '0);
    full_c     = (count_q == CNT_W'(DEPTH));
    in_ready   = !full_c;
`ifdef FETCH_BUF_BYPASS_EN
    bypass_c   = empty_c && in_valid && out_ready && !flush;
    head_c     = empty_c ? in_entry_c : mem_q[rd_ptr_q];
    out_valid  = (!empty_c || in_valid) && !flush;
`else
    bypass_c   = 1'b0;
    head_c     = mem_q[rd_ptr_q];
    out_valid  = !empty_c && !flush;
`endif
    push_c     = in_valid && !full_c && !flush && !bypass_c;
    pop_c      = !empty_c && out_ready && !flush;
  end

  assign out_pc             = head_c.pc;
  assign out_instr          = head_c.instr;
  assign out_guesses_branch = head_c.guesses_branch;
  assign out_prediction     = head_c.prediction;
  assign occupancy          = count_q;

  // Pointer and count update; flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push_c) mem_d[wr_ptr_q] = in_entry_c;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (default and FETCH_BUF_BYPASS_EN builds).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_fetch_buffer;

  logic                   clk = 1'b0;
  logic                   n_rst;
  logic                   in_valid;
  logic [`ADDR_WIDTH-1:0] in_pc;
  logic [31:0]            in_instr;
  logic                   in_guesses_branch;
  logic [`ADDR_WIDTH-1:0] in_prediction;
  logic                   in_ready;
  logic                   out_valid;
  logic [`ADDR_WIDTH-1:0] out_pc;
  logic [31:0]            out_instr;
  logic                   out_guesses_branch;
  logic [`ADDR_WIDTH-1:0] out_prediction;
  logic                   out_ready;
  logic                   flush;
  logic [3:0]             occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_buffer #(.DEPTH(8)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .in_valid           (in_valid),
    .in_pc              (in_pc),
    .in_instr           (in_instr),
    .in_guesses_branch  (in_guesses_branch),
    .in_prediction      (in_prediction),
    .in_ready           (in_ready),
    .out_valid          (out_valid),
    .out_pc             (out_pc),
    .out_instr          (out_instr),
    .out_guesses_branch (out_guesses_branch),
    .out_prediction     (out_prediction),
    .out_ready          (out_ready),
    .flush              (flush),
    .occupancy          (occupancy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [31:0] pc);
    in_valid          = v;
    in_pc             = `ADDR_WIDTH'(pc);
    in_instr          = pc ^ 32'hA5A5_0000;
    in_guesses_branch = pc[2];
    in_prediction     = `ADDR_WIDTH'(pc + 32'h40);
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive_in(1'b1, base + 32'(4 * i));
      cyc();
    end
    drive_in(1'b0, 32'h0);
  endtask

  task automatic test_reset();
    n_rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive_in(1'b0, 32'h0);
    cyc(); cyc();
    n_rst = 1'b1;
    #1;
    n_checks++;
    if (occupancy !== 4'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: occ=%0d in_ready=%b out_valid=%b, need 0/1/0", occupancy, in_ready, out_valid);
    end
  endtask

  task automatic test_fill();
    push_n(8, 32'h100);
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || occupancy !== 4'd8) begin
      n_fail++;
      $display("FAIL fill_full: in_ready=%b occ=%0d, need 0/8", in_ready, occupancy);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== `ADDR_WIDTH'(32'h100 + 32'(4 * i))) begin
        n_fail++;
        $display("FAIL fill_drain[%0d]: valid=%b pc=%h, need 1/%h", i, out_valid, out_pc, 32'h100 + 32'(4 * i));
      end
      cyc();
    end
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (occupancy !== 4'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_empty: occ=%0d valid=%b, need 0/0", occupancy, out_valid);
    end
  endtask

  task automatic test_full_with_pop();
    logic [31:0] exp_pc [8];
    push_n(8, 32'h400);
    drive_in(1'b1, 32'h500);
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_pc !== `ADDR_WIDTH'(32'h400)) begin
      n_fail++;
      $display("FAIL full_pop_pre: in_ready=%b pc=%h, need 0/400", in_ready, out_pc);
    end
    cyc();
    n_checks++;
    if (occupancy !== 4'd7 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop_refused: occ=%0d in_ready=%b, need 7/1", occupancy, in_ready);
    end
    cyc();
    drive_in(1'b0, 32'h0);
    #1;
    n_checks++;
    if (occupancy !== 4'd7) begin
      n_fail++;
      $display("FAIL full_pop_accept: occ=%0d, need 7", occupancy);
    end
    for (int i = 0; i < 6; i++) exp_pc[i] = 32'h408 + 32'(4 * i);
    exp_pc[6] = 32'h500;
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== `ADDR_WIDTH'(exp_pc[i])) begin
        n_fail++;
        $display("FAIL full_pop_drain[%0d]: valid=%b pc=%h, need 1/%h", i, out_valid, out_pc, exp_pc[i]);
      end
      cyc();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int sent = 0;
    int recv = 0;
    logic [31:0] epc;
    for (int c = 0; c < 200 && recv < 20; c++) begin
      drive_in(sent < 20, 32'h800 + 32'(4 * sent));
      out_ready = (c % 2 == 0);
      #1;
      if (out_valid && out_ready) begin
        epc = 32'h800 + 32'(4 * recv);
        n_checks++;
        if (out_pc !== `ADDR_WIDTH'(epc) || out_instr !== (epc ^ 32'hA5A5_0000) ||
            out_guesses_branch !== epc[2] || out_prediction !== `ADDR_WIDTH'(epc + 32'h40)) begin
          n_fail++;
          $display("FAIL wrap[%0d]: pc=%h instr=%h gb=%b pred=%h, need pc=%h", recv, out_pc,
                   out_instr, out_guesses_branch, out_prediction, epc);
        end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      cyc();
    end
    drive_in(1'b0, 32'h0);
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (recv !== 20 || occupancy !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_done: recv=%0d occ=%0d, need 20/0", recv, occupancy);
    end
  endtask

  task automatic test_flush();
    push_n(5, 32'h600);
    #1;
    n_checks++;
    if (occupancy !== 4'd5) begin
      n_fail++;
      $display("FAIL flush_pre: occ=%0d, need 5", occupancy);
    end
    flush = 1'b1;
    drive_in(1'b1, 32'h200);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cycle_valid: valid=%b, need 0", out_valid);
    end
    cyc();
    flush = 1'b0;
    drive_in(1'b0, 32'h0);
    #1;
    n_checks++;
    if (occupancy !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_after: occ=%0d valid=%b in_ready=%b, need 0/0/1", occupancy, out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_no_output[%0d]: valid=%b pc=%h, need valid 0", i, out_valid, out_pc);
      end
    end
    push_n(1, 32'h210);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== `ADDR_WIDTH'(32'h210)) begin
      n_fail++;
      $display("FAIL flush_resume: valid=%b pc=%h, need 1/210", out_valid, out_pc);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    push_n(3, 32'h900);
    n_rst = 1'b0;
    cyc();
    n_rst = 1'b1;
    #1;
    n_checks++;
    if (occupancy !== 4'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: occ=%0d in_ready=%b valid=%b, need 0/1/0", occupancy, in_ready, out_valid);
    end
    push_n(1, 32'h700);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== `ADDR_WIDTH'(32'h700) || occupancy !== 4'd1) begin
      n_fail++;
      $display("FAIL reset_mid_first: valid=%b pc=%h occ=%0d, need 1/700/1", out_valid, out_pc, occupancy);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic test_bypass();
    drive_in(1'b1, 32'h300);
    out_ready = 1'b1;
    #1;
`ifdef FETCH_BUF_BYPASS_EN
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== `ADDR_WIDTH'(32'h300)) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: valid=%b pc=%h, need 1/300", out_valid, out_pc);
    end
    cyc();
    drive_in(1'b0, 32'h0);
    #1;
    n_checks++;
    if (occupancy !== 4'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_not_stored: occ=%0d valid=%b, need 0/0", occupancy, out_valid);
    end
`else
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL nobypass_same_cycle: valid=%b, need 0", out_valid);
    end
    cyc();
    drive_in(1'b0, 32'h0);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== `ADDR_WIDTH'(32'h300) || occupancy !== 4'd1) begin
      n_fail++;
      $display("FAIL nobypass_next_cycle: valid=%b pc=%h occ=%0d, need 1/300/1", out_valid, out_pc, occupancy);
    end
    cyc();
    n_checks++;
    if (occupancy !== 4'd0) begin
      n_fail++;
      $display("FAIL nobypass_drained: occ=%0d, need 0", occupancy);
    end
`endif
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_with_pop();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
